seq_detect_ctrl: RTL

SEQ_DETECT_CTRL -- requirements
Module: seq_detect_ctrl

---
 rtl/seq_detect_ctrl_pkg.sv | 14 +
 rtl/seq_detect_ctrl_if.sv | 25 ++
 rtl/seq_match_core.sv | 52 +++++
 rtl/seq_detect_ctrl.sv | 117 +++++++++++
 4 files changed

// File: rtl/seq_detect_ctrl_pkg.sv
// Shared definitions for the serial pattern detector: the state encoding and
// the default pattern length and counter width.
package seq_detect_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int DEF_MAX_LEN = 8;
    localparam int DEF_CNT_W   = 8;

endpackage

// File: rtl/seq_detect_ctrl_if.sv
// Configuration write channel: a valid/ready handshake carrying the pattern,
// its length, the overlap mode and the hit target.
interface seq_detect_ctrl_if
    import seq_detect_ctrl_pkg::*;
#(
    parameter int MAX_LEN = DEF_MAX_LEN,
    parameter int CNT_W   = DEF_CNT_W
);
    logic               cfg_valid;
    logic               cfg_ready;
    logic [MAX_LEN-1:0] cfg_pattern;
    logic [3:0]         cfg_len;
    logic               cfg_overlap;
    logic [CNT_W-1:0]   cfg_target;

    modport master (
        output cfg_valid, cfg_pattern, cfg_len, cfg_overlap, cfg_target,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid, cfg_pattern, cfg_len, cfg_overlap, cfg_target,
        output cfg_ready
    );
endinterface

// File: rtl/seq_match_core.sv
// History shift register, fill counter and masked compare. o_hit reports a
// match that includes the bit being shifted in this cycle.
module seq_match_core #(
    parameter int MAX_LEN = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_clear,
    input  logic               i_shift,
    input  logic               i_din,
    input  logic [3:0]         i_len,
    input  logic [MAX_LEN-1:0] i_pattern,
    input  logic               i_overlap,
    output logic               o_hit
);
    localparam int FILL_W = $clog2(MAX_LEN + 1);

    logic [MAX_LEN-1:0] r_hist;
    logic [FILL_W-1:0]  r_fill;
    logic [MAX_LEN-1:0] w_next_hist;
    logic [FILL_W-1:0]  w_fill_inc;
    logic               w_match;

    assign w_next_hist = {r_hist[MAX_LEN-2:0], i_din};
    assign w_fill_inc  = (r_fill == FILL_W'(MAX_LEN)) ? r_fill : r_fill + 1'b1;

    // NOTE: w_match is given a value before the loop so no path leaves it unassigned (no latch).
    always_comb begin
        w_match = 1'b1;
        for (int i = 0; i < MAX_LEN; i++) begin
            if (i < int'(i_len) && w_next_hist[i] != i_pattern[i]) begin
                w_match = 1'b0;
            end
        end
    end

    assign o_hit = i_shift && w_match && (int'(w_fill_inc) >= int'(i_len));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hist <= '0;
            r_fill <= '0;
        end else if (i_clear) begin
            r_hist <= '0;
            r_fill <= '0;
        end else if (i_shift) begin
            r_hist <= w_next_hist;
            // Non-overlapping mode restarts the fill so old bits cannot join the next match.
            r_fill <= (o_hit && !i_overlap) ? '0 : w_fill_inc;
        end
    end
endmodule

// File: rtl/seq_detect_ctrl.sv
// Serial pattern detector: configuration registers, IDLE/RUN/DONE sequencing
// and a saturating hit counter around the seq_match_core compare engine.
module seq_detect_ctrl
    import seq_detect_ctrl_pkg::*;
#(
    parameter int MAX_LEN = DEF_MAX_LEN,
    parameter int CNT_W   = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    seq_detect_ctrl_if.slave cfg,
    input  logic             start,
    input  logic             abort,
    input  logic             din,
    input  logic             din_valid,
    output logic             z,
    output logic             busy,
    output logic             done,
    output logic             cfg_err,
    output logic [CNT_W-1:0] hit_count
);
    localparam logic [4:0] LEN_MAX = 5'(MAX_LEN);

    state_t             r_state;
    logic [MAX_LEN-1:0] r_pattern;
    logic [3:0]         r_len;
    logic               r_overlap;
    logic [CNT_W-1:0]   r_target;
    logic               r_cfg_err;
    logic               r_z;
    logic               r_busy;
    logic               r_done;
    logic [CNT_W-1:0]   r_hit_count;

    logic               w_clear;
    logic               w_shift;
    logic               w_hit;
    logic [CNT_W-1:0]   w_count_inc;

    assign cfg.cfg_ready = (r_state == ST_IDLE);
    assign w_clear       = (r_state == ST_IDLE) && start && !r_cfg_err;
    // Abort takes priority over a completing bit, so the bit is never shifted in.
    assign w_shift       = (r_state == ST_RUN) && din_valid && !abort;
    assign w_count_inc   = (&r_hit_count) ? r_hit_count : r_hit_count + 1'b1;

    seq_match_core #(.MAX_LEN(MAX_LEN)) u_core (
        .clk       (clk),
        .rst       (rst),
        .i_clear   (w_clear),
        .i_shift   (w_shift),
        .i_din     (din),
        .i_len     (r_len),
        .i_pattern (r_pattern),
        .i_overlap (r_overlap),
        .o_hit     (w_hit)
    );

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_pattern   <= '0;
            r_len       <= 4'd1;
            r_overlap   <= 1'b0;
            r_target    <= '0;
            r_cfg_err   <= 1'b0;
            r_z         <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_hit_count <= '0;
        end else begin
            r_z    <= 1'b0;
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (cfg.cfg_valid) begin
                        r_pattern <= cfg.cfg_pattern;
                        r_len     <= cfg.cfg_len;
                        r_overlap <= cfg.cfg_overlap;
                        r_target  <= cfg.cfg_target;
                        r_cfg_err <= (cfg.cfg_len == 4'd0) || ({1'b0, cfg.cfg_len} > LEN_MAX);
                    end
                    if (start && !r_cfg_err) begin
                        r_state     <= ST_RUN;
                        r_busy      <= 1'b1;
                        r_hit_count <= '0;
                    end
                end
                ST_RUN: begin
                    if (abort) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end else if (w_hit) begin
                        r_z         <= 1'b1;
                        r_hit_count <= w_count_inc;
                        if (r_target != '0 && w_count_inc == r_target) begin
                            r_state <= ST_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end
                    end
                end
                ST_DONE: r_state <= ST_IDLE;
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign z         = r_z;
    assign busy      = r_busy;
    assign done      = r_done;
    assign cfg_err   = r_cfg_err;
    assign hit_count = r_hit_count;
endmodule
